// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - FSM state and owner encodings shared by the memory bus arbiter
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_DONE  = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_owner_t;

   // Width of a counter that must hold 0..max inclusive.
   function automatic int cnt_w(input int max);
      return (max < 1) ? 1 : $clog2(max + 1);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_grant.sv
// rtl/mem_bus_arbiter_arb_grant.sv - D-over-I priority with a saturating starvation counter
module arb_grant
   import mem_bus_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   localparam int CW = cnt_w(STARVE_MAX)
) (
   input  logic clk,
   input  logic rst,
   input  logic grant_en,
   input  logic inst_req,
   input  logic data_req,
   output logic grant_i,
   output logic grant_d
);

   logic [CW-1:0] starve_cnt;
   logic          i_wins;

   always_comb begin
      i_wins  = inst_req && (!data_req || (starve_cnt == CW'(STARVE_MAX)));
      grant_i = grant_en && i_wins;
      grant_d = grant_en && data_req && !i_wins;
   end

   // Counts D grants that overtook a waiting I; reaching the limit hands the next slot to I.
   always_ff @(posedge clk) begin
      if (rst)
         starve_cnt <= '0;
      else if (grant_i)
         starve_cnt <= '0;
      else if (grant_d && inst_req && (starve_cnt != CW'(STARVE_MAX)))
         starve_cnt <= starve_cnt + 1'b1;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one SRAM-like bus between I-fetch and D ports
// Optional MEM_ERR_CHK_EN: zero-strobe D stores complete with data_err instead of going to the bus.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic [DATA_W-1:0]   inst_rdata,
   output logic                inst_data_ok,
   input  logic                data_req,
   input  logic                data_wr,
   input  logic [DATA_W/8-1:0] data_wstrb,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                data_data_ok,
   output logic                data_err,
   output logic                bus_req,
   output logic                bus_wr,
   output logic [DATA_W/8-1:0] bus_wstrb,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic                bus_addr_ok,
   input  logic                bus_data_ok,
   input  logic [DATA_W-1:0]   bus_rdata,
   output logic                arb_busy
);

   arb_state_t state;
   arb_owner_t owner;
   logic       grant_i;
   logic       grant_d;
   logic       finish;
   logic       err_store;

   arb_grant #(
      .STARVE_MAX (STARVE_MAX)
   ) u_grant (
      .clk      (clk),
      .rst      (rst),
      .grant_en (state == ARB_IDLE),
      .inst_req (inst_req),
      .data_req (data_req),
      .grant_i  (grant_i),
      .grant_d  (grant_d)
   );

`ifdef MEM_ERR_CHK_EN
   assign err_store = data_wr && (data_wstrb == '0);

   always_ff @(posedge clk) begin
      if (rst)
         data_err <= 1'b0;
      else
         data_err <= grant_d && err_store;
   end
`else
   assign err_store = 1'b0;
   assign data_err  = 1'b0;
`endif

   assign finish   = ((state == ARB_ISSUE) && bus_addr_ok && bus_data_ok) ||
                     ((state == ARB_WAIT) && bus_data_ok);
   assign arb_busy = (state != ARB_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ARB_IDLE;
         owner        <= OWN_I;
         bus_req      <= 1'b0;
         bus_wr       <= 1'b0;
         bus_wstrb    <= '0;
         bus_addr     <= '0;
         bus_wdata    <= '0;
         inst_rdata   <= '0;
         data_rdata   <= '0;
         inst_data_ok <= 1'b0;
         data_data_ok <= 1'b0;
      end else begin
         inst_data_ok <= 1'b0;
         data_data_ok <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (grant_i) begin
                  owner     <= OWN_I;
                  bus_wr    <= 1'b0;
                  bus_wstrb <= '0;
                  bus_addr  <= inst_addr;
                  bus_wdata <= '0;
                  bus_req   <= 1'b1;
                  state     <= ARB_ISSUE;
               end else if (grant_d) begin
                  owner     <= OWN_D;
                  bus_wr    <= data_wr;
                  bus_wstrb <= data_wstrb;
                  bus_addr  <= data_addr;
                  bus_wdata <= data_wdata;
                  // A trapped store never touches the bus and completes straight away.
                  if (err_store) begin
                     data_data_ok <= 1'b1;
                     state        <= ARB_DONE;
                  end else begin
                     bus_req <= 1'b1;
                     state   <= ARB_ISSUE;
                  end
               end
            end
            ARB_ISSUE: begin
               if (bus_addr_ok) begin
                  bus_req <= 1'b0;
                  state   <= bus_data_ok ? ARB_DONE : ARB_WAIT;
               end
            end
            ARB_WAIT: begin
               if (bus_data_ok)
                  state <= ARB_DONE;
            end
            ARB_DONE: state <= ARB_IDLE;
            default:  state <= ARB_IDLE;
         endcase

         // Stores leave rdata untouched so the last load value stays visible.
         if (finish) begin
            if (owner == OWN_I) begin
               inst_data_ok <= 1'b1;
               inst_rdata   <= bus_rdata;
            end else begin
               data_data_ok <= 1'b1;
               if (!bus_wr)
                  data_rdata <= bus_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, data_req, data_wr;
   logic [31:0] inst_addr, data_addr, data_wdata;
   logic [3:0]  data_wstrb;
   logic [31:0] inst_rdata, data_rdata;
   logic        inst_data_ok, data_data_ok, data_err;
   logic        bus_req, bus_wr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic        bus_addr_ok, bus_data_ok;
   logic        arb_busy;

   int n_chk = 0;
   int n_err = 0;

   bit          mfree, rel, in_flight, exp_own, exp_wr, exp_err, data_wait;
   bit          fix_rd, d_fix, fix_wr;
   logic [31:0] exp_addr, exp_wdata, exp_irdata, exp_drdata, rsp_next;
   logic [31:0] fix_val, fix_addr, fix_wdata;
   logic [3:0]  exp_wstrb, fix_wstrb;
   int          starve, addr_cnt, d_dly, data_cnt, nstep, dok_step;
   int          exp_lat, last_lat, req_cycles, dummy;
   bit          order_q[$];
   bit          exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(data_rdata), .data_data_ok(data_data_ok), .data_err(data_err),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .arb_busy(arb_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock; then the bus slave reacts to what the arbiter shows after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (in_flight) nstep++;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = $urandom;
      if (data_wait) begin
         if (data_cnt == 0) begin
            bus_data_ok = 1'b1;
            bus_rdata   = rsp_next;
            data_wait   = 1'b0;
            dok_step    = nstep;
         end else data_cnt--;
      end else if (bus_req) begin
         if (addr_cnt == 0) begin
            bus_addr_ok = 1'b1;
            if (d_dly == 0) begin
               bus_data_ok = 1'b1;
               bus_rdata   = rsp_next;
               dok_step    = nstep;
            end else begin
               data_wait = 1'b1;
               data_cnt  = d_dly - 1;
            end
         end else addr_cnt--;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      inst_req = 0; data_req = 0; data_wr = 0;
      inst_addr = 0; data_addr = 0; data_wdata = 0; data_wstrb = 0;
      bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
      mfree = 1; rel = 0; in_flight = 0; starve = 0; data_wait = 0; addr_cnt = 0;
      exp_irdata = 0; exp_drdata = 0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic new_i();
      inst_req  = 1'b1;
      inst_addr = $urandom;
   endtask

   task automatic new_d();
      data_req = 1'b1;
      if (d_fix) begin
         data_wr = fix_wr; data_addr = fix_addr; data_wstrb = fix_wstrb; data_wdata = fix_wdata;
      end else begin
         data_wr    = 1'($urandom_range(1));
         data_addr  = $urandom;
         data_wstrb = ($urandom_range(5) == 0) ? 4'h0 : 4'($urandom_range(15));
         data_wdata = $urandom;
      end
   endtask

   // Reference arbitration: D first unless I has been passed over SMAX times.
   task automatic grant(input int amin, input int amax, input int dmin, input int dmax);
      bit od;
      od = data_req && !(inst_req && (starve == SMAX));
      if (od) begin
         if (inst_req && starve < SMAX) starve++;
      end else starve = 0;
      exp_own = od;
      order_q.push_back(od);
      if (od) begin
         exp_wr = data_wr; exp_addr = data_addr; exp_wstrb = data_wstrb; exp_wdata = data_wdata;
      end else begin
         exp_wr = 1'b0; exp_addr = inst_addr; exp_wstrb = 4'h0; exp_wdata = 32'h0;
      end
`ifdef MEM_ERR_CHK_EN
      exp_err = od && data_wr && (data_wstrb == 4'h0);
`else
      exp_err = 1'b0;
`endif
      addr_cnt   = $urandom_range(amax, amin);
      d_dly      = $urandom_range(dmax, dmin);
      exp_lat    = exp_err ? 1 : 2 + addr_cnt + d_dly;
      rsp_next   = fix_rd ? fix_val : $urandom;
      in_flight  = 1'b1;
      mfree      = 1'b0;
      nstep      = 0;
      req_cycles = 0;
   endtask

   task automatic observe(inout int done_n);
      if (!in_flight || exp_err) chk("bus_idle", bus_req, 0);
      else if (bus_req) begin
         req_cycles++;
         if (exp_wr) chk("bus_fields", {bus_wr, bus_addr, bus_wstrb, bus_wdata}, {exp_wr, exp_addr, exp_wstrb, exp_wdata});
         else        chk("bus_fields", {bus_wr, bus_addr}, {1'b0, exp_addr});
      end
      if (in_flight && (inst_data_ok || data_data_ok)) begin
         chk("owner", {inst_data_ok, data_data_ok}, {!exp_own, exp_own});
         chk("latency", nstep, exp_lat);
         chk("err", data_err, exp_err);
         if (!exp_err) chk("ok_after_bus", nstep - dok_step, 1);
         if (exp_own) begin
            if (!exp_wr) exp_drdata = rsp_next;
            chk("d_rdata", data_rdata, exp_drdata);
            data_req = 1'b0;
         end else begin
            exp_irdata = rsp_next;
            chk("i_rdata", inst_rdata, exp_irdata);
            inst_req = 1'b0;
         end
         last_lat  = nstep;
         in_flight = 1'b0;
         rel       = 1'b1;
         done_n++;
      end else chk("quiet", {inst_data_ok, data_data_ok, data_err}, 3'b000);
   endtask

   task automatic run(input int n, input int pi, input int pd,
                      input int amin, input int amax, input int dmin, input int dmax);
      int done_n = 0;
      int budget = 0;
      while (done_n < n && budget < 3000) begin
         budget++;
         if (!inst_req && $urandom_range(99) < pi) new_i();
         if (!data_req && $urandom_range(99) < pd) new_d();
         if (mfree && (inst_req || data_req)) grant(amin, amax, dmin, dmax);
         if (rel) begin mfree = 1'b1; rel = 1'b0; end
         step();
         observe(done_n);
         if (in_flight && nstep > 60) begin
            chk("timeout", nstep, exp_lat);
            do_reset();
         end
      end
      chk("run_count", done_n, n);
   endtask

   task automatic quiesce();
      inst_req = 1'b0;
      data_req = 1'b0;
      repeat (3) begin
         step();
         observe(dummy);
      end
      mfree = 1'b1;
      rel   = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      fix_rd = 0; d_fix = 0; fix_wr = 0; fix_val = 0; fix_addr = 0; fix_wdata = 0; fix_wstrb = 0;
      dummy = 0; last_lat = 0; dok_step = 0; nstep = 0; req_cycles = 0;
      do_reset();
      chk("rst_busy", arb_busy, 0);
      chk("rst_bus_req", bus_req, 0);
      chk("rst_bus_fields", {bus_wr, bus_addr, bus_wstrb, bus_wdata}, 0);
      chk("rst_oks", {inst_data_ok, data_data_ok, data_err}, 0);
      chk("rst_rdata", {inst_rdata, data_rdata}, 0);

      // I-only load, immediate address ack, data one cycle later
      fix_rd = 1; fix_val = 32'h1234_5678;
      run(1, 100, 0, 0, 0, 1, 1);
      chk("i_only_lat", last_lat, 3);
      chk("i_only_rdata", inst_rdata, 32'h1234_5678);
      quiesce();
      fix_rd = 0;

      // both ports always requesting: starvation relief order
      do_reset();
      order_q.delete();
      run(10, 100, 100, 0, 0, 0, 2);
      chk("order_len", order_q.size(), 10);
      if (order_q.size() >= 10)
         for (int k = 0; k < 10; k++) chk("grant_order", order_q[k], exp_order[k]);
      quiesce();

      // store with address phase held off for three cycles
      do_reset();
      d_fix = 1; fix_wr = 1; fix_addr = 32'h100; fix_wstrb = 4'b0011; fix_wdata = 32'hBEEF_BEEF;
      run(1, 0, 100, 3, 3, 1, 1);
      chk("st_lat", last_lat, 6);
      chk("st_req_cycles", req_cycles, 4);
      chk("st_rdata_hold", data_rdata, 0);
      quiesce();

      // address and data acks in the same ISSUE cycle skip WAIT
      run(1, 0, 100, 0, 0, 0, 0);
      chk("skip_wait_lat", last_lat, 2);
      quiesce();

      // zero-strobe store
      fix_wstrb = 4'b0000;
      run(1, 0, 100, 0, 0, 1, 1);
`ifdef MEM_ERR_CHK_EN
      chk("zs_lat", last_lat, 1);
      chk("zs_req_cycles", req_cycles, 0);
`else
      chk("zs_lat", last_lat, 3);
      chk("zs_req_cycles", req_cycles, 1);
`endif
      quiesce();
      d_fix = 0;

      // reset during WAIT abandons the load; the late bus ack must be ignored
      do_reset();
      new_d();
      data_wr = 1'b0;
      grant(0, 0, 6, 6);
      step();
      step();
      chk("rst_pre_busy", arb_busy, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      data_req = 1'b0;
      chk("rst_mid_busy", arb_busy, 0);
      chk("rst_mid_bus_req", bus_req, 0);
      chk("rst_mid_ok", {inst_data_ok, data_data_ok}, 0);
      in_flight = 0; mfree = 1; rel = 0; starve = 0; exp_irdata = 0; exp_drdata = 0;
      repeat (8) begin
         step();
         observe(dummy);
      end
      chk("rst_mid_busy_after", arb_busy, 0);
      chk("rst_mid_rdata", data_rdata, 0);

      // mixed random traffic
      do_reset();
      run(60, 30, 40, 0, 3, 0, 3);
      quiesce();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
